fsm1: RTL and testbench

- Moore-type serial sequence detector.
- Samples a 1-bit serial input X on each rising clock edge and asserts Z for exactly one cycle after the overlapping pattern 1-0-0-1 has been received.
- Exposes its 3-bit state register for debug and observation.
- Used as a small control/detection leaf in lab-level designs.

---
 rtl/fsm1_pkg.sv | 18 +
 rtl/fsm1.sv | 40 ++++
 tb/tb_fsm1.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fsm1_pkg.sv
// Shared constants for the fsm1 serial 1-0-0-1 sequence detector.
// State encodings are fixed so the debug state output is stable across builds.
package fsm1_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    // Detection pattern, oldest bit first.
    localparam logic [3:0] PATTERN = 4'b1001;

endpackage

// File: rtl/fsm1.sv
// Moore detector for the overlapping serial pattern 1-0-0-1 on X.
// Z is decoded from the state register only, so X never reaches Z combinationally.
module fsm1
    import fsm1_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               X,
    output logic               Z,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Unused encodings fall back to idle.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = X ? S1 : S0;
            S1:      state_d = X ? S1 : S2;
            S2:      state_d = X ? S1 : S3;
            S3:      state_d = X ? S4 : S0;
            S4:      state_d = X ? S1 : S2;
            default: state_d = S0;
        endcase
    end

    assign Z     = (state_q == S4);
    assign state = state_q;

endmodule

// File: tb/tb_fsm1.sv
// Directed bench for fsm1: reset, detection, overlap, near misses,
// async reset mid-sequence and recovery from unused encodings.
module tb_fsm1;
    import fsm1_pkg::*;

    logic       clk;
    logic       reset;
    logic       X;
    logic       Z;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    fsm1 dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Z     (Z),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive X mid-cycle, let one rising edge sample it, then check state and Z.
    task automatic step(input string tag, input logic x, input logic [2:0] exp_state);
        @(negedge clk);
        X = x;
        @(posedge clk);
        #1;
        check({tag, "_state"}, state, exp_state);
        check({tag, "_z"}, {2'b00, Z}, {2'b00, exp_state == 3'b100});
    endtask

    // Async reset pulse between edges.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("pulse_rst_state", state, 3'b000);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic illegal(input logic [2:0] enc);
        @(negedge clk);
        force dut.state_q = enc;
        #1;
        check("illegal_forced_z", {2'b00, Z}, 3'b000);
        release dut.state_q;
        X = 1'b1;
        @(posedge clk);
        #1;
        check("illegal_recover_state", state, 3'b000);
        check("illegal_recover_z", {2'b00, Z}, 3'b000);
    endtask

    logic       basic_x [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    logic [2:0] basic_s [11] = '{0, 0, 0, 1, 2, 3, 4, 2, 1, 2, 3};
    logic       ovl_x   [7]  = '{1, 0, 0, 1, 0, 0, 1};
    logic [2:0] ovl_s   [7]  = '{1, 2, 3, 4, 2, 3, 4};
    logic       nm_x    [6]  = '{1, 0, 1, 0, 0, 0};
    logic [2:0] nm_s    [6]  = '{1, 2, 1, 2, 3, 0};

    initial begin
        reset = 1'b0;
        X     = 1'b0;

        // Reset held low while X toggles and the clock runs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            X = ~X;
            @(posedge clk);
            #1;
            check("rst_hold_state", state, 3'b000);
            check("rst_hold_z", {2'b00, Z}, 3'b000);
        end
        @(negedge clk);
        X     = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_release_state", state, 3'b000);
        X = 1'b0;

        for (int i = 0; i < 11; i++) step("basic", basic_x[i], basic_s[i]);

        pulse_reset();
        for (int i = 0; i < 7; i++) step("overlap", ovl_x[i], ovl_s[i]);

        pulse_reset();
        for (int i = 0; i < 6; i++) step("near_miss", nm_x[i], nm_s[i]);
        for (int i = 0; i < 3; i++) step("ones", 1'b1, 3'b001);

        // Async reset from S3 discards the partial match.
        pulse_reset();
        step("pre_async", 1'b1, 3'b001);
        step("pre_async", 1'b0, 3'b010);
        step("pre_async", 1'b0, 3'b011);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_state", state, 3'b000);
        check("async_z", {2'b00, Z}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        step("post_async", 1'b1, 3'b001);

        illegal(3'b110);
        illegal(3'b101);
        illegal(3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
